regfile_sb: RTL

Parametrised general-purpose register file for the pipelined CPU with N combinational read ports, one write port and an integrated per-register scoreboard. Destinations are reserved at issue; the busy bit is cleared at writeback. It sits between decode (read/issue side) and writeback (write side) and replaces the fixed two-port register file. Hazard-detection logic uses the busy outputs to stall.

---
 rtl/regfile_sb_pkg.sv | 12 +
 rtl/regfile_sb_rdport.sv | 50 +++++
 rtl/regfile_sb.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding on reads).
package regfile_sb_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_SIZE       = 32;

    // Register x0 is hardwired to zero and can never be reserved.
    localparam logic [REG_ADDR_WIDTH-1:0] X0_ADDR = '0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: array mux, x0 gating and, when
// REGFILE_BYPASS_EN is defined, write-through forwarding from the
// writeback port together with the same-cycle issue override of busy.
module regfile_sb_rdport
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_WIDTH,
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int NUM_REGS = REG_SIZE
) (
    input  logic [ADDR_W-1:0]          addr,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [NUM_REGS-1:0]        busy_vec,
`ifdef REGFILE_BYPASS_EN
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
`endif
    output logic [DATA_W-1:0]          data,
    output logic                       busy
);

    logic is_x0;
    assign is_x0 = (addr == ADDR_W'(X0_ADDR));

`ifdef REGFILE_BYPASS_EN
    logic wr_hit;
    assign wr_hit = wr_en && (wr_addr != ADDR_W'(X0_ADDR)) && (wr_addr == addr);
`endif

    // Select stored value and busy bit, forwarding the writeback when enabled.
    always_comb begin
        data = regs_flat[int'(addr)*DATA_W +: DATA_W];
        busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit) begin
            data = wr_data;
            // A new producer issued in the same cycle keeps the register busy.
            busy = iss_en && (iss_addr == addr);
        end
`endif
        if (is_x0) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule : regfile_sb_rdport

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one write port and a
// per-register busy scoreboard (set at issue, cleared at writeback).
// Optional feature macro: REGFILE_BYPASS_EN (see regfile_sb_rdport).
// There is no valid/ready handshake anywhere: wr_*, iss_* and flush_i are
// qualified only by their own enables and are taken at every rising edge.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_WIDTH,
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int NUM_REGS = REG_SIZE,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          busy_cnt_o
);

    logic [DATA_W-1:0]          mem [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        busy;
    logic [NUM_REGS-1:0]        busy_next;
    logic [ADDR_W:0]            cnt_next;
    logic                       wr_ok;
    logic                       iss_ok;

    assign wr_ok  = wr_en_i  && (wr_addr_i  != ADDR_W'(X0_ADDR));
    assign iss_ok = iss_en_i && (iss_addr_i != ADDR_W'(X0_ADDR));

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = mem[g];
    end

    // Next busy vector: flush beats issue, issue beats writeback clear.
    always_comb begin
        busy_next = busy;
        if (flush_i) begin
            busy_next = '0;
        end else begin
            if (wr_ok) begin
                busy_next[wr_addr_i] = 1'b0;
            end
            if (iss_ok) begin
                busy_next[iss_addr_i] = 1'b1;
            end
        end
    end

    // Population count of the next busy vector, registered into busy_cnt_o.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
        end
    end

    // State update: reset wins over everything; writeback data ignores flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            busy       <= '0;
            busy_cnt_o <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr_i] <= wr_data_i;
            end
            busy       <= busy_next;
            busy_cnt_o <= cnt_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_sb_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_REGS (NUM_REGS)
        ) u_rdport (
            .addr      (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .regs_flat (regs_flat),
            .busy_vec  (busy),
`ifdef REGFILE_BYPASS_EN
            .wr_en     (wr_en_i),
            .wr_addr   (wr_addr_i),
            .wr_data   (wr_data_i),
            .iss_en    (iss_en_i),
            .iss_addr  (iss_addr_i),
`endif
            .data      (rd_data_o[k*DATA_W +: DATA_W]),
            .busy      (rd_busy_o[k])
        );
    end

endmodule : regfile_sb
